// File: rtl/char2numb.sv
// Parses a decimal digit stream into an unsigned binary value; a non-digit terminates the number.
// Latency: the result is valid the cycle after the terminator is accepted.
// Backpressure: char_ready stays low while a result waits in HOLD; characters are stalled, never dropped.
module char2numb #(
  parameter int MAX_DIGITS = 4,
  parameter int OUT_W      = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             char_valid,
  input  logic [6:0]       char_code,
  output logic             char_ready,
  output logic             numb_valid,
  input  logic             numb_ready,
  output logic [OUT_W-1:0] numb_value,
  output logic [2:0]       numb_len,
  output logic             numb_ovf
);

  localparam logic [6:0] C_0 = 7'h30;
  localparam logic [6:0] C_1 = 7'h31;
  localparam logic [6:0] C_2 = 7'h32;
  localparam logic [6:0] C_3 = 7'h33;
  localparam logic [6:0] C_4 = 7'h34;
  localparam logic [6:0] C_5 = 7'h35;
  localparam logic [6:0] C_6 = 7'h36;
  localparam logic [6:0] C_7 = 7'h37;
  localparam logic [6:0] C_8 = 7'h38;
  localparam logic [6:0] C_9 = 7'h39;

  localparam int         ACC_W   = OUT_W + 4;
  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] acc_nxt;
  logic [2:0]       cnt;
  logic             ovf;
  logic             is_dig;
  logic [3:0]       dig;
  logic             char_fire;

  // Digit decode is a per-code compare so the character map can change freely.
  always_comb begin
    is_dig = 1'b1;
    dig    = 4'd0;
    case (char_code)
      C_0:     dig = 4'd0;
      C_1:     dig = 4'd1;
      C_2:     dig = 4'd2;
      C_3:     dig = 4'd3;
      C_4:     dig = 4'd4;
      C_5:     dig = 4'd5;
      C_6:     dig = 4'd6;
      C_7:     dig = 4'd7;
      C_8:     dig = 4'd8;
      C_9:     dig = 4'd9;
      default: is_dig = 1'b0;
    endcase
  end

  // Widened multiply-add; the OUT_W/MAX_DIGITS relation makes the truncation lossless.
  assign acc_nxt   = OUT_W'(ACC_W'(acc) * ACC_W'(10) + ACC_W'(dig));
  assign char_fire = char_valid && char_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    char_ready = 1'b0;
    numb_valid = 1'b0;
    case (state)
      IDLE: begin
        char_ready = 1'b1;
        if (char_valid && is_dig) state_nxt = ACCUM;
      end
      ACCUM: begin
        char_ready = 1'b1;
        if (char_valid && !is_dig) state_nxt = HOLD;
      end
      HOLD: begin
        numb_valid = 1'b1;
        if (numb_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      numb_value <= '0;
      numb_len   <= '0;
      numb_ovf   <= 1'b0;
    end else if (char_fire) begin
      case (state)
        IDLE: begin
          if (is_dig) begin
            acc <= OUT_W'(dig);
            cnt <= 3'd1;
            ovf <= 1'b0;
          end
        end
        ACCUM: begin
          if (is_dig) begin
            if (cnt < MAX_CNT) begin
              acc <= acc_nxt;
              cnt <= cnt + 3'd1;
            end else begin
              ovf <= 1'b1;
            end
          end else begin
            numb_value <= acc;
            numb_len   <= cnt;
            numb_ovf   <= ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_char2numb.sv
// Randomized and directed bench for char2numb with a digit-list reference model and result scoreboard.
module tb_char2numb;

  localparam int MAXD = 4;
  localparam int OW   = 14;
  localparam logic [6:0] SP = 7'h20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          char_valid;
  logic [6:0]    char_code;
  logic          char_ready;
  logic          numb_valid;
  logic          numb_ready;
  logic [OW-1:0] numb_value;
  logic [2:0]    numb_len;
  logic          numb_ovf;

  char2numb #(.MAX_DIGITS(MAXD), .OUT_W(OW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_valid (char_valid),
    .char_code  (char_code),
    .char_ready (char_ready),
    .numb_valid (numb_valid),
    .numb_ready (numb_ready),
    .numb_value (numb_value),
    .numb_len   (numb_len),
    .numb_ovf   (numb_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    int len;
    bit ovf;
  } res_t;

  logic [6:0] dig_tab[10] = '{7'h30, 7'h31, 7'h32, 7'h33, 7'h34, 7'h35, 7'h36, 7'h37, 7'h38, 7'h39};
  logic [6:0] sep_tab[6]  = '{7'h20, 7'h41, 7'h00, 7'h7f, 7'h2f, 7'h3a};

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   term_cyc = -10;
  bit   rand_rdy = 1'b0;
  res_t exp_q[$];
  int   dq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int code_digit(input logic [6:0] c);
    for (int i = 0; i < 10; i++)
      if (c == dig_tab[i]) return i;
    return -1;
  endfunction

  // Reference: collect digits; a terminator after at least one digit yields the first MAXD digits as a number.
  task automatic model_accept(input logic [6:0] c);
    int   d;
    int   n;
    res_t r;
    d = code_digit(c);
    if (d >= 0) begin
      dq.push_back(d);
    end else if (dq.size() > 0) begin
      n     = dq.size();
      r.len = (n > MAXD) ? MAXD : n;
      r.ovf = (n > MAXD);
      r.val = 0;
      for (int i = 0; i < r.len; i++) r.val = r.val * 10 + dq[i];
      exp_q.push_back(r);
      dq.delete();
      term_cyc = cyc;
    end
  endtask

  task automatic send_char(input logic [6:0] c);
    int w;
    w          = 0;
    char_code  = c;
    char_valid = 1'b1;
    @(negedge clk);
    while (!char_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!char_ready) begin
      checks++;
      errors++;
      $display("FAIL char_accept_timeout: char_ready stuck at 0 for code %0h", c);
      char_valid = 1'b0;
    end else begin
      model_accept(c);
      @(posedge clk);
      #1;
      char_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_numb_valid"}, int'(numb_valid), 0);
    chk({tag, "_char_ready"}, int'(char_ready), 1);
    chk({tag, "_numb_value"}, int'(numb_value), 0);
    chk({tag, "_numb_len"},   int'(numb_len),   0);
    chk({tag, "_numb_ovf"},   int'(numb_ovf),   0);
  endtask

  // Random consumer readiness while in the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) numb_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: result scoreboard plus HOLD-state protocol checks.
  initial begin
    bit   prev_hold;
    int   prev_val;
    int   prev_len;
    res_t r;
    prev_hold = 1'b0;
    prev_val  = 0;
    prev_len  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (term_cyc == cyc - 1) chk("valid_after_term", int'(numb_valid), 1);
        if (numb_valid) begin
          chk("hold_char_ready", int'(char_ready), 0);
          if (prev_hold) begin
            chk("hold_value_stable", int'(numb_value), prev_val);
            chk("hold_len_stable", int'(numb_len), prev_len);
          end
        end
        prev_hold = numb_valid && !numb_ready;
        prev_val  = int'(numb_value);
        prev_len  = int'(numb_len);
        if (numb_valid && numb_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: value %0d len %0d with nothing expected", numb_value, numb_len);
          end else begin
            r = exp_q.pop_front();
            chk("result_value", int'(numb_value), r.val);
            chk("result_len",   int'(numb_len),   r.len);
            chk("result_ovf",   int'(numb_ovf),   int'(r.ovf));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] c;
    int         w;
    rst_n      = 1'b0;
    char_valid = 1'b0;
    char_code  = 7'h00;
    numb_ready = 1'b1;
    idle(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    // Basic parse, separators, zero, max value, overflow and recovery.
    send_char(dig_tab[1]); send_char(dig_tab[2]); send_char(dig_tab[3]); send_char(SP);
    idle(3);
    send_char(SP); send_char(SP); send_char(dig_tab[0]); send_char(SP);
    idle(3);
    for (int i = 0; i < 4; i++) send_char(dig_tab[9]);
    send_char(SP);
    for (int i = 1; i <= 6; i++) send_char(dig_tab[i]);
    send_char(SP);
    send_char(dig_tab[7]); send_char(SP);
    idle(3);

    // Backpressure: consumer stalls while the next number waits at the source.
    numb_ready = 1'b0;
    send_char(dig_tab[4]); send_char(dig_tab[2]); send_char(SP);
    fork
      begin
        send_char(dig_tab[8]);
        send_char(SP);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          chk("bp_numb_valid", int'(numb_valid), 1);
          chk("bp_char_ready", int'(char_ready), 0);
          chk("bp_numb_value", int'(numb_value), 42);
        end
        @(posedge clk);
        #1;
        numb_ready = 1'b1;
      end
    join
    idle(3);

    // Reset in the middle of a number: partial value is discarded.
    send_char(dig_tab[5]); send_char(dig_tab[6]);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    dq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_char(dig_tab[3]); send_char(SP);
    idle(3);

    // Reset while a result is held.
    numb_ready = 1'b0;
    send_char(dig_tab[1]); send_char(SP);
    #2;
    chk("hold_before_reset", int'(numb_valid), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_hold");
    exp_q.delete();
    dq.delete();
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    numb_ready = 1'b1;
    idle(3);

    // Random stream with random consumer stalls and idle gaps.
    rand_rdy = 1'b1;
    repeat (400) begin
      if ($urandom_range(0, 9) < 6) c = dig_tab[$urandom_range(0, 9)];
      else                          c = sep_tab[$urandom_range(0, 5)];
      send_char(c);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    send_char(SP);
    rand_rdy   = 1'b0;
    numb_ready = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      w++;
      idle(1);
    end
    idle(2);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
